ssr6_to_ssr4_gearbox: RTL and testbench

Converts a 6-samples-per-clock stream, valid on two of every three clocks, back to a continuous 4-samples-per-clock stream. It is the read-side counterpart of the 4-to-6 SSR front end used by the 2/3-band filters. It sits after the SSR6 filter core and feeds the downstream SSR4 datapath. It replaces the fixed-phase output converter with an occupancy-tracked ring buffer, so alignment does not depend on a global clock phase, and it flags underflow and overflow.

---
 rtl/ssr6_to_ssr4_gearbox.sv | 114 +++++++++++
 tb/tb_ssr6_to_ssr4_gearbox.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ssr6_to_ssr4_gearbox.sv
// 6-samples/clock (2-of-3 duty) to continuous 4-samples/clock converter.
// Occupancy-tracked 24-sample ring with priming, sticky underflow/overflow flags.
module ssr6_to_ssr4_gearbox #(
    parameter int NBITS       = 13,
    parameter int DEPTH       = 24,
    parameter int PRIME_LEVEL = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ce_i,
    input  logic [6*NBITS-1:0] dat_i,
    output logic [4*NBITS-1:0] dat_o,
    output logic               valid_o,
    output logic               underflow_o,
    output logic               overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] WR_LAST = PTR_W'(DEPTH - 6);
    localparam logic [PTR_W-1:0] RD_LAST = PTR_W'(DEPTH - 4);
    localparam logic [5:0] OCC_WR_MAX = 6'(DEPTH - 6);
    localparam logic [5:0] PRIME_OCC  = 6'(PRIME_LEVEL);

    typedef enum logic {
        PRIME,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   ring_q [DEPTH];
    logic [NBITS-1:0]   ring_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [5:0]         occ_q, occ_d, occ_rd;
    logic [4*NBITS-1:0] dat_q, dat_d, rd_word;
    logic               valid_q, valid_d;
    logic               underflow_q, underflow_d;
    logic               overflow_q, overflow_d;
    logic               rd_en, wr_en, ovf;

    // Entry gi belongs to write slot gi/6, lane gi%6; wr only lands on slot starts.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ring_wr
        localparam int LANE = gi % 6;
        localparam logic [PTR_W-1:0] SLOT = PTR_W'(gi - LANE);
        assign ring_d[gi] = (wr_en && (wr_q == SLOT)) ? dat_i[LANE*NBITS +: NBITS]
                                                      : ring_q[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ring_rd
        assign rd_word[gi*NBITS +: NBITS] = ring_q[rd_q + PTR_W'(gi)];
    end

    always_comb begin
        rd_en  = (state_q == RUN) && (occ_q >= 6'd4);
        occ_rd = rd_en ? (occ_q - 6'd4) : occ_q;
        // Overflow is judged after this cycle's read has freed its space.
        ovf    = ce_i && (occ_rd > OCC_WR_MAX);
        wr_en  = ce_i && !ovf;
        occ_d  = wr_en ? (occ_rd + 6'd6) : occ_rd;

        wr_d = wr_q;
        if (wr_en) begin
            wr_d = (wr_q == WR_LAST) ? '0 : (wr_q + PTR_W'(6));
        end
        rd_d = rd_q;
        if (rd_en) begin
            rd_d = (rd_q == RD_LAST) ? '0 : (rd_q + PTR_W'(4));
        end

        state_d = state_q;
        case (state_q)
            PRIME:   if (occ_d >= PRIME_OCC) state_d = RUN;
            RUN:     if (!rd_en) state_d = PRIME;
            default: state_d = PRIME;
        endcase

        valid_d     = rd_en;
        dat_d       = rd_en ? rd_word : '0;
        underflow_d = underflow_q | ((state_q == RUN) && !rd_en);
        overflow_d  = overflow_q | ovf;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= PRIME;
            wr_q        <= '0;
            rd_q        <= '0;
            occ_q       <= '0;
            dat_q       <= '0;
            valid_q     <= 1'b0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            occ_q       <= occ_d;
            dat_q       <= dat_d;
            valid_q     <= valid_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    // Ring contents need no reset: occupancy guards every read.
    always_ff @(posedge clk_i) begin
        ring_q <= ring_d;
    end

    assign dat_o       = dat_q;
    assign valid_o     = valid_q;
    assign underflow_o = underflow_q;
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ssr6_to_ssr4_gearbox.sv
// Scoreboard bench: a sample-queue reference model predicts each output cycle.
module tb_ssr6_to_ssr4_gearbox;

    localparam int NB = 13;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic            ce_i;
    logic [6*NB-1:0] dat_i;
    logic [4*NB-1:0] dat_o;
    logic            valid_o, underflow_o, overflow_o;

    always #5 clk = ~clk;

    ssr6_to_ssr4_gearbox #(.NBITS(NB), .DEPTH(24), .PRIME_LEVEL(8)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .ce_i        (ce_i),
        .dat_i       (dat_i),
        .dat_o       (dat_o),
        .valid_o     (valid_o),
        .underflow_o (underflow_o),
        .overflow_o  (overflow_o)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: FIFO of samples plus a primed/running flag.
    logic [NB-1:0]   mq[$];
    bit              m_run, m_uf, m_of;
    logic [4*NB-1:0] exp_q[$];
    logic [2:0]      ctl_q[$];
    int              ramp = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6*NB-1:0] rand_word();
        logic [6*NB-1:0] w;
        for (int k = 0; k < 6; k++) w[k*NB +: NB] = NB'($urandom_range(0, (1 << NB) - 1));
        return w;
    endfunction

    function automatic logic [6*NB-1:0] ramp_word();
        logic [6*NB-1:0] w;
        for (int k = 0; k < 6; k++) w[k*NB +: NB] = NB'(ramp + k);
        ramp += 6;
        return w;
    endfunction

    // Drive one cycle and predict the outputs after the edge that ends it.
    task automatic drive(input bit rst_n, input bit ce, input logic [6*NB-1:0] d);
        bit              rd, was_run;
        logic [4*NB-1:0] w;
        @(negedge clk);
        rst_ni = rst_n;
        ce_i   = ce;
        dat_i  = d;
        if (!rst_n) begin
            mq.delete();
            m_run = 0;
            m_uf  = 0;
            m_of  = 0;
            ctl_q.push_back(3'b000);
        end else begin
            was_run = m_run;
            rd      = m_run && (mq.size() >= 4);
            if (rd) begin
                for (int k = 0; k < 4; k++) w[k*NB +: NB] = mq.pop_front();
                exp_q.push_back(w);
            end
            if (ce) begin
                if (mq.size() + 6 > 24) m_of = 1;
                else for (int k = 0; k < 6; k++) mq.push_back(d[k*NB +: NB]);
            end
            if (was_run && !rd) begin
                m_uf  = 1;
                m_run = 0;
            end else if (!was_run && mq.size() >= 8) begin
                m_run = 1;
            end
            ctl_q.push_back({rd, m_uf, m_of});
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, rand_word());
        ramp = 0;
    endtask

    // pat is msb-first ce sequence repeated every 3 cycles; ce=0 cycles carry junk.
    task automatic run_pat(input int ncyc, input logic [2:0] pat, input bit chk_start);
        bit ce;
        for (int n = 0; n < ncyc; n++) begin
            ce = pat[2 - (n % 3)];
            drive(1'b1, ce, ce ? ramp_word() : rand_word());
            if (chk_start && n == 0) begin
                chk("reset_dat", dat_o, 0);
                chk("reset_flags", {underflow_o, overflow_o}, 0);
            end
            if (chk_start && n <= 4) chk($sformatf("start_valid_c%0d", n), valid_o, (n >= 3));
        end
    endtask

    task automatic run_random(input int ncyc);
        int ph;
        bit ce;
        ph = $urandom_range(0, 2);
        for (int n = 0; n < ncyc; n++) begin
            ce = ((n + ph) % 3) != 2;
            drive(1'b1, ce, rand_word());
        end
    endtask

    // Monitor: compare every cycle that the stimulus has predicted.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (ctl_q.size() > 0) begin
                e = ctl_q.pop_front();
                chk("ctrl{valid,uf,of}", {valid_o, underflow_o, overflow_o}, e);
                if (e[2]) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL data: got %0h expected <empty scoreboard>", dat_o);
                    end else begin
                        chk("data", dat_o, exp_q.pop_front());
                    end
                end else begin
                    chk("idle_dat_zero", dat_o, 0);
                end
            end
        end
    end

    initial begin
        rst_ni = 1'b0;
        ce_i   = 1'b0;
        dat_i  = '0;

        // 110 ramp, long enough for many pointer wraps
        do_reset(2);
        run_pat(120, 3'b110, 1'b1);
        chk("s1_flags", {underflow_o, overflow_o}, 0);

        // 101 as first pattern
        do_reset(1);
        run_pat(60, 3'b101, 1'b0);
        chk("s2_flags", {underflow_o, overflow_o}, 0);

        // steady, then starve, then resume
        do_reset(1);
        run_pat(30, 3'b110, 1'b0);
        run_pat(6, 3'b000, 1'b0);
        chk("s3_underflow", underflow_o, 1);
        chk("s3_valid_low", valid_o, 0);
        run_pat(30, 3'b110, 1'b0);

        // continuous ce from reset
        do_reset(1);
        run_pat(40, 3'b111, 1'b0);
        chk("s4_overflow", overflow_o, 1);

        // mid-run single-cycle reset, restart identical to the first scenario
        do_reset(1);
        run_pat(20, 3'b110, 1'b0);
        do_reset(1);
        run_pat(30, 3'b110, 1'b1);

        // random data with a random legal 2-of-3 phase
        do_reset(1);
        run_random(150);
        run_pat(10, 3'b000, 1'b0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
